// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract controller.
package add_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NIB_W       = 4;
    localparam int MAX_NIBBLES = 16;
    localparam int MAX_W       = NIB_W * MAX_NIBBLES;

    // Returns nibble i of v; callers zero-extend narrower operands to MAX_W.
    function automatic logic [NIB_W-1:0] nib_sel(input logic [MAX_W-1:0] v,
                                                 input int unsigned      i);
        return v[i*NIB_W +: NIB_W];
    endfunction

endpackage

// File: rtl/add_seq_ctrl_add_nibble.sv
// Combinational 4-bit adder slice with carry in/out, shared by every pass.
module add_nibble
    import add_seq_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    assign {co, s} = (NIB_W+1)'(x) + (NIB_W+1)'(y) + (NIB_W+1)'(ci);

endmodule

// File: rtl/add_seq_ctrl.sv
// Nibble-serial W-bit add/subtract sequencer: one 4-bit slice, NIBBLES passes,
// LSB nibble first, start/busy/done handshake with results held after done.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sub,
    input  logic                     cin,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state, state_next;
    logic [W-1:0]       op_a, op_b;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       sum_next;
    logic [NIB_W-1:0]   slice_x, slice_y, slice_s;
    logic               slice_co;
    logic               accept;
    logic               last;

    // DONE accepts a new request exactly like IDLE, giving NIBBLES+1 throughput.
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (idx == IDX_W'(NIBBLES - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    assign slice_x = nib_sel(MAX_W'(op_a), 32'(idx));
    assign slice_y = nib_sel(MAX_W'(op_b), 32'(idx));

    add_nibble u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last)   state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sum_next = sum;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) sum_next[i*NIB_W +: NIB_W] = slice_s;
        end
    end

    // NOTE: operand registers are loaded on every accept before any use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= a;
            op_b <= sub ? ~b : b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            carry <= sub ? 1'b1 : cin;
        end else if (state == RUN) begin
            sum   <= sum_next;
            carry <= slice_co;
            idx   <= last ? '0 : idx + IDX_W'(1);
            if (last) begin
                cout <= slice_co;
                ovf  <= (op_a[W-1] == op_b[W-1]) && (slice_s[NIB_W-1] != op_a[W-1]);
            end
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (NIBBLES=4): directed table, random ops
// against an arithmetic model, and multi-cycle handshake/reset sequences.
module tb_add_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
    localparam int LAT     = NIBBLES + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, sub, cin;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout, ovf;

    int checks = 0;
    int errors = 0;

    add_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sub;
        logic         cin;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model from plain integer arithmetic on the full-width values.
    task automatic model(input logic s, input logic c, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic co, output logic ov);
        int sx, sy, sr;
        int unsigned t;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r  = x - y;
            co = (x >= y);
            sr = sx - sy;
        end else begin
            t  = 32'(x) + 32'(y) + 32'(c);
            r  = t[W-1:0];
            co = (t > 32'hFFFF);
            sr = sx + sy + int'(c);
        end
        ov = (sr > 32767) || (sr < -32768);
    endtask

    task automatic run_op(input logic s, input logic c, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] es, input logic eco, input logic eov, input string tag);
        int edges;
        bit hs_ok;
        @(negedge clk);
        sub = s; cin = c; a = x; b = y; start = 1'b1;
        edges = 0;
        hs_ok = 1'b1;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (edges < LAT && (!busy || done)) hs_ok = 1'b0;
            if (done && busy) hs_ok = 1'b0;
        end while (!done && edges < 20);
        check({tag, " latency"}, 32'(edges), 32'(LAT));
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(eco));
        check({tag, " ovf"}, 32'(ovf), 32'(eov));
        check({tag, " handshake"}, 32'(hs_ok), 32'd1);
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " sum held"}, 32'(sum), 32'(es));
    endtask

    initial begin
        vec_t         vecs[6];
        logic [W-1:0] er;
        logic         eco, eov;
        logic [W-1:0] rx, ry;
        logic         rs, rc;
        int           dones, edges;
        logic [W-1:0] sum_at_done;

        vecs[0] = '{sub:1'b0, cin:1'b0, a:16'h1234, b:16'h0FFF, sum:16'h2233, cout:1'b0, ovf:1'b0};
        vecs[1] = '{sub:1'b0, cin:1'b0, a:16'hFFFF, b:16'h0001, sum:16'h0000, cout:1'b1, ovf:1'b0};
        vecs[2] = '{sub:1'b0, cin:1'b1, a:16'hFFFF, b:16'h0001, sum:16'h0001, cout:1'b1, ovf:1'b0};
        vecs[3] = '{sub:1'b1, cin:1'b0, a:16'h0005, b:16'h0007, sum:16'hFFFE, cout:1'b0, ovf:1'b0};
        vecs[4] = '{sub:1'b1, cin:1'b1, a:16'h8000, b:16'h0001, sum:16'h7FFF, cout:1'b1, ovf:1'b1};
        vecs[5] = '{sub:1'b0, cin:1'b0, a:16'h7FFF, b:16'h0001, sum:16'h8000, cout:1'b0, ovf:1'b1};

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #1;
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            rc = 1'($urandom);
            rx = W'($urandom);
            ry = W'($urandom);
            if (i % 8 == 0) ry = 16'h8000 - rx;
            model(rs, rc, rx, ry, er, eco, eov);
            run_op(rs, rc, rx, ry, er, eco, eov, $sformatf("rnd%0d", i));
        end

        // Second start during RUN with different operands must be ignored.
        @(negedge clk);
        sub = 1'b0; cin = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sub = 1'b1; a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        sum_at_done = '0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dones++;
                sum_at_done = sum;
            end
            @(negedge clk);
        end
        check("runstart done count", 32'(dones), 32'd1);
        check("runstart sum", 32'(sum_at_done), 32'h3333);

        // Leave cout/ovf set so the reset below has something to clear.
        run_op(1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, "pre-reset");

        @(negedge clk);
        sub = 1'b0; a = 16'h4321; b = 16'h1111; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun rst sum", 32'(sum), 32'd0);
        check("midrun rst cout", 32'(cout), 32'd0);
        check("midrun rst ovf", 32'(ovf), 32'd0);
        check("midrun rst busy", 32'(busy), 32'd0);
        check("midrun rst done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrun rst no done", 32'(dones), 32'd0);
        run_op(1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, "post-reset");

        // Back-to-back: start held high, second op accepted in DONE.
        @(negedge clk);
        sub = 1'b0; cin = 1'b0; a = 16'h0F0F; b = 16'h0101; start = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!done && edges < 20);
        check("b2b first latency", 32'(edges), 32'(LAT));
        check("b2b first sum", 32'(sum), 32'h1010);
        sub = 1'b1; a = 16'h2000; b = 16'h0001;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
        end while (!done && edges < 20);
        check("b2b second latency", 32'(edges), 32'(LAT));
        check("b2b second sum", 32'(sum), 32'h1FFF);
        check("b2b second cout", 32'(cout), 32'd1);
        check("b2b second ovf", 32'(ovf), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Sequencing controller that performs a W-bit add or subtract by driving one 4-bit nibble adder slice over NIBBLES consecutive cycles, least-significant nibble first, with a registered carry between passes. It sits between the control logic that issues arithmetic requests and the nibble datapath. It trades throughput for area where a full-width adder is not justified. Start/busy/done handshake; results held stable until the next accepted start.

## Interface
- NIBBLES, 4, number of 4-bit passes; operand width W = 4*NIBBLES; legal range 1..16
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- sub  input  1  1 = a - b, 0 = a + b + cin; sampled with start
- cin  input  1  carry-in for add; ignored when sub=1
- a  input  W  operand A; sampled with start
- b  input  W  operand B; sampled with start
- busy  output  1  high while passes are in progress
- done  output  1  one-cycle pulse when the result is valid
- sum  output  W  result; held until the next accepted start
- cout  output  1  final carry out; for sub, 1 = no borrow
- ovf  output  1  two's-complement overflow of the W-bit result

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 is accepted on the next clk edge. On acceptance:
  - latch a into op_a
  - latch (sub ? ~b : b) into op_b
  - carry <= (sub ? 1 : cin)
  - idx <= 0
  - next state RUN
- RUN: on each cycle, the slice computes {c, s} = op_a[idx] + op_b[idx] + carry, where [idx] is nibble idx.
  - Each edge writes s into sum nibble idx, sets carry <= c and increments idx.
  - After the edge with idx = NIBBLES-1, go to DONE.
  - cout <= c at that same edge.
  - ovf <= (a[W-1] == op_b[W-1]) && (s[3] != a[W-1]), using the latched MSBs.
- DONE: done=1 for exactly one cycle; next state IDLE. A start in DONE is accepted at that edge, exactly as in IDLE: new operands are latched and the next state is RUN.
- start while in RUN is ignored; it is neither queued nor errored.
- sum, cout and ovf change only during RUN passes of an accepted operation. They are otherwise held, including through IDLE.
- sum nibbles above idx retain their previous-operation values until overwritten. Consumers must qualify the result with done, or with busy=0 after a done.
- Reset, at any time including mid-RUN:
  - state=IDLE, idx=0, carry=0
  - sum=0, cout=0, ovf=0, busy=0, done=0
  - the in-flight operation is discarded with no done pulse

## Timing
- busy = (state==RUN), driven directly from the registered state.
- done = (state==DONE), driven directly from the registered state.
- start sampled at edge E0 → busy high from E0 through edge E0+NIBBLES.
- done high for the cycle after edge E0+NIBBLES. Total latency start-to-done = NIBBLES+1 edges.
- Back-to-back throughput: one operation per NIBBLES+1 cycles, by holding start high.
- The slice path is combinational within one cycle. The 4-bit add plus carry mux must meet clk.
- idx width = clog2(NIBBLES), minimum 1 bit. With NIBBLES=1, RUN lasts one cycle.

## Structure
- Shared package add_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - localparam NIB_W = 4
  - nibble-select helper function
- Sub-module add_nibble:
  - inputs x[3:0], y[3:0], ci
  - outputs s[3:0], co
  - purely combinational; instantiated once and shared across all passes
- Controller holds all registers: op_a, op_b, carry, idx, state, sum, cout, ovf.

## Test plan
- NIBBLES=4, a=0x1234, b=0x0FFF, sub=0, cin=0 → done 5 edges after start; sum=0x2233, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Repeat with cin=1 → sum=0x0001, cout=1.
- sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0 (borrow), ovf=0. Also a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- a=0x7FFF, b=0x0001, add → sum=0x8000, ovf=1, cout=0.
- Start pulsed again during RUN with different operands → ignored; first result correct; exactly one done pulse.
- Assert rst two cycles into RUN → all outputs 0 immediately (async); no done. A following start of 0x0001+0x0001 → sum=0x0002.
